// File: rtl/qpsk_burst_ctrl.sv
// qpsk_burst_ctrl
// Sequences the serial bit stream into the QPSK modulator. Each accepted
// start sends a fixed preamble (MSB first), then passes exactly
// 2*burst_syms payload bits from the upstream stage to the modulator.
// An abort ends the payload early. If a half symbol is outstanding, one
// zero bit is padded first, so every burst hands the modulator an even
// number of bits and the next burst stays pair-aligned.
//
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-high reset
//   start, burst_syms  burst request and payload length (symbols), IDLE only
//   abort              early payload termination, DATA only
//   src_data/valid/ready  upstream bit stream (ready is an output)
//   mod_data/valid, mod_ready  modulator bit stream
//   busy               high in every state except IDLE
//   done, aborted      one-cycle end-of-burst pulse and its abort flag
//   sym_count          payload symbols delivered in the current/last burst
module qpsk_burst_ctrl #(
    parameter int BURST_LEN_W   = 12,
    parameter int PREAMBLE_SYMS = 4,
    parameter logic [((PREAMBLE_SYMS > 0) ? 2*PREAMBLE_SYMS : 1)-1:0] PREAMBLE_PATTERN = 8'b0011_0110
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [BURST_LEN_W-1:0] burst_syms,
    input  logic                   abort,
    input  logic                   src_data,
    input  logic                   src_valid,
    output logic                   src_ready,
    output logic                   mod_data,
    output logic                   mod_valid,
    input  logic                   mod_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic [BURST_LEN_W-1:0] sym_count
);

    localparam int CW = BURST_LEN_W + 1;
    localparam int PW = (PREAMBLE_SYMS > 0) ? 2*PREAMBLE_SYMS : 1;
    localparam logic [CW-1:0] PRE_LAST = CW'(PW - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_DATA     = 3'd2,
        S_PAD      = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [BURST_LEN_W-1:0] len_q, len_d;
    logic                   aborted_q, aborted_d;

    logic                   xfer_s;
    logic [CW-1:0]          cnt_inc_s;
    logic [CW-1:0]          last_bit_s;
    logic [PW-1:0]          pre_shift_s;

    // Shifting the pattern left by the bit count puts the next preamble bit at the MSB.
    assign pre_shift_s = PREAMBLE_PATTERN << bit_cnt_q;
    assign xfer_s      = mod_valid & mod_ready;
    assign cnt_inc_s   = bit_cnt_q + {{(CW-1){1'b0}}, xfer_s};
    // Index of the final payload bit, 2*len-1; the counter is one bit wider so it never wraps.
    assign last_bit_s  = {len_q, 1'b0} - CNT_ONE;

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign aborted   = aborted_q;
    // The preamble reuses the bit counter, so hide it from the symbol count.
    assign sym_count = (state_q == S_PREAMBLE) ? {BURST_LEN_W{1'b0}} : bit_cnt_q[CW-1:1];

    // Stream-side outputs; DATA is a zero-latency pass-through between the two handshakes.
    always_comb begin
        src_ready = 1'b0;
        mod_valid = 1'b0;
        mod_data  = 1'b0;
        case (state_q)
            S_PREAMBLE: begin
                mod_valid = 1'b1;
                mod_data  = pre_shift_s[PW-1];
            end
            S_DATA: begin
                mod_valid = src_valid;
                mod_data  = src_data;
                src_ready = mod_ready;
            end
            S_PAD: begin
                mod_valid = 1'b1;
                mod_data  = 1'b0;
            end
            default: begin
                mod_valid = 1'b0;
            end
        endcase
    end

    // Next-state, bit counter, latched length and abort flag.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        len_d     = len_q;
        aborted_d = aborted_q;
        case (state_q)
            S_IDLE: begin
                if (start && (burst_syms != {BURST_LEN_W{1'b0}})) begin
                    len_d     = burst_syms;
                    aborted_d = 1'b0;
                    bit_cnt_d = {CW{1'b0}};
                    state_d   = (PREAMBLE_SYMS > 0) ? S_PREAMBLE : S_DATA;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PREAMBLE: begin
                if (xfer_s) begin
                    if (bit_cnt_q == PRE_LAST) begin
                        state_d   = S_DATA;
                        bit_cnt_d = {CW{1'b0}};
                    end else begin
                        bit_cnt_d = cnt_inc_s;
                    end
                end else begin
                    state_d = S_PREAMBLE;
                end
            end
            S_DATA: begin
                bit_cnt_d = cnt_inc_s;
                // A completing transfer takes priority over a same-cycle abort.
                if (xfer_s && (bit_cnt_q == last_bit_s)) begin
                    state_d = S_DONE;
                end else if (abort) begin
                    // Parity after this cycle's transfer decides whether a half symbol is open.
                    if (cnt_inc_s[0]) begin
                        state_d = S_PAD;
                    end else begin
                        state_d   = S_DONE;
                        aborted_d = 1'b1;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PAD: begin
                if (xfer_s) begin
                    bit_cnt_d = cnt_inc_s;
                    aborted_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    state_d = S_PAD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= {CW{1'b0}};
            len_q     <= {BURST_LEN_W{1'b0}};
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            len_q     <= len_d;
            aborted_q <= aborted_d;
        end
    end

endmodule

// File: tb/tb_qpsk_burst_ctrl.sv
// Self-checking bench for qpsk_burst_ctrl. A burst-level model tracks
// preamble bits remaining, payload bits delivered and pending pad/done. It
// is compared against every DUT output on every falling clock edge.
// Directed bursts pin the delivered bit stream to hand-computed literals.
// A random phase then exercises the handshakes, aborts, stray starts and
// reset.
module tb_qpsk_burst_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [11:0] burst_syms = 12'd0;
    logic        abort = 1'b0;
    logic        src_data = 1'b0;
    logic        src_valid = 1'b0;
    logic        mod_ready = 1'b0;
    logic        src_ready, mod_data, mod_valid, busy, done, aborted;
    logic [11:0] sym_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int src_idx = 0;
    int src_base = 0;
    bit rnd_mode = 1'b0;
    bit got_q[$];
    int done_cnt = 0;
    int done_cyc = 0;
    logic [11:0] done_sym = 12'd0;
    logic        done_ab = 1'b0;
    bit   src_pat [16];
    logic [7:0] pre_pat = 8'b0011_0110;

    // burst-level model
    bit m_active = 1'b0;
    bit m_done_now = 1'b0;
    bit m_pad = 1'b0;
    bit m_aborted = 1'b0;
    int m_pre_left = 0;
    int m_pay_sent = 0;
    int m_len = 0;

    qpsk_burst_ctrl dut (
        .clock(clock), .reset(reset), .start(start), .burst_syms(burst_syms),
        .abort(abort), .src_data(src_data), .src_valid(src_valid),
        .src_ready(src_ready), .mod_data(mod_data), .mod_valid(mod_valid),
        .mod_ready(mod_ready), .busy(busy), .done(done), .aborted(aborted),
        .sym_count(sym_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out at t=%0t", nm, $time);
    endtask

    // cycle counter and upstream consumption counter
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (src_valid && src_ready) src_idx <= src_idx + 1;
    end

    // compare process: model vs DUT every cycle, then advance the model
    always @(negedge clock) begin : cmp
        logic e_rdy, e_val, e_dat;
        bit   xf;
        if (reset) begin
            chk("rst_src_ready", 32'(src_ready), 32'd0);
            chk("rst_mod_valid", 32'(mod_valid), 32'd0);
            chk("rst_mod_data",  32'(mod_data),  32'd0);
            chk("rst_busy",      32'(busy),      32'd0);
            chk("rst_done",      32'(done),      32'd0);
            chk("rst_aborted",   32'(aborted),   32'd0);
            chk("rst_sym_count", 32'(sym_count), 32'd0);
            m_active = 1'b0; m_done_now = 1'b0; m_pad = 1'b0; m_aborted = 1'b0;
            m_pre_left = 0; m_pay_sent = 0; m_len = 0;
        end else begin
            e_rdy = 1'b0; e_val = 1'b0; e_dat = 1'b0;
            if (m_active && !m_done_now) begin
                if (m_pre_left > 0) begin
                    e_val = 1'b1;
                    e_dat = pre_pat[m_pre_left-1];
                end else if (m_pad) begin
                    e_val = 1'b1;
                end else begin
                    e_val = src_valid;
                    e_dat = src_data;
                    e_rdy = mod_ready;
                end
            end
            chk("src_ready", 32'(src_ready), 32'(e_rdy));
            chk("mod_valid", 32'(mod_valid), 32'(e_val));
            chk("mod_data",  32'(mod_data),  32'(e_dat));
            chk("busy",      32'(busy),      32'(m_active));
            chk("done",      32'(done),      32'(m_done_now));
            chk("aborted",   32'(aborted),   32'(m_aborted));
            chk("sym_count", 32'(sym_count), 32'(m_pay_sent / 2));
            if (mod_valid && mod_ready) got_q.push_back(mod_data);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                done_sym = sym_count;
                done_ab  = aborted;
            end
            xf = src_valid && mod_ready;
            if (m_done_now) begin
                m_done_now = 1'b0;
                m_active   = 1'b0;
            end else if (!m_active) begin
                if (start && burst_syms != 12'd0) begin
                    m_active = 1'b1; m_pre_left = 8; m_pay_sent = 0;
                    m_len = int'(burst_syms); m_aborted = 1'b0; m_pad = 1'b0;
                end
            end else if (m_pre_left > 0) begin
                if (mod_ready) m_pre_left--;
            end else if (m_pad) begin
                if (mod_ready) begin
                    m_pay_sent++; m_pad = 1'b0; m_done_now = 1'b1; m_aborted = 1'b1;
                end
            end else begin
                if (xf) m_pay_sent++;
                if (xf && m_pay_sent == 2*m_len) begin
                    m_done_now = 1'b1;
                end else if (abort) begin
                    if (m_pay_sent % 2 == 1) m_pad = 1'b1;
                    else begin m_done_now = 1'b1; m_aborted = 1'b1; end
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        if (!rnd_mode) src_data = src_pat[(src_idx - src_base) % 16];
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        burst_syms = 12'(n);
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int k = 0;
        int d0 = done_cnt;
        while (done_cnt == d0 && k < budget) begin step(); k++; end
        if (done_cnt == d0) fail_timeout(nm);
    endtask

    task automatic wait_src(input string nm, input int n, input int budget);
        int k = 0;
        while ((src_idx - src_base) < n && k < budget) begin step(); k++; end
        if ((src_idx - src_base) < n) fail_timeout(nm);
    endtask

    task automatic prep();
        got_q.delete();
        src_base = src_idx;
        src_valid = 1'b1;
        mod_ready = 1'b1;
        abort = 1'b0;
        src_data = src_pat[0];
    endtask

    function automatic logic [31:0] pack_got(input int n);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < n && i < got_q.size(); i++) v = {v[30:0], 1'(got_q[i])};
        return v;
    endfunction

    initial begin : stim
        int t0, d0, k;
        for (int i = 0; i < 16; i++) src_pat[i] = 1'b0;
        src_pat[0] = 1'b1; src_pat[2] = 1'b1; src_pat[3] = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step(); step();
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_sym", 32'(sym_count), 32'd0);

        // basic burst of 3 symbols
        prep();
        do_start(3);
        t0 = cyc;
        wait_done("t1_done", 100);
        chk("t1_len", 32'(got_q.size()), 32'd14);
        chk("t1_bits", pack_got(14), 32'h0000_0DAC);
        chk("t1_sym", 32'(done_sym), 32'd3);
        chk("t1_ab", 32'(done_ab), 32'd0);
        chk("t1_latency", 32'(done_cyc - t0), 32'd14);

        // same burst with mod_ready toggling
        prep();
        do_start(3);
        mod_ready = 1'b1;
        d0 = done_cnt; k = 0;
        while (done_cnt == d0 && k < 100) begin step(); mod_ready = ~mod_ready; k++; end
        if (done_cnt == d0) fail_timeout("t2_done");
        chk("t2_bits", pack_got(14), 32'h0000_0DAC);
        chk("t2_sym", 32'(done_sym), 32'd3);

        // abort after 3 payload bits -> pad
        prep();
        do_start(5);
        wait_src("t3_src", 3, 50);
        src_valid = 1'b0; abort = 1'b1;
        step();
        abort = 1'b0;
        wait_done("t3_done", 50);
        chk("t3_len", 32'(got_q.size()), 32'd12);
        chk("t3_bits", pack_got(12), 32'h0000_036A);
        chk("t3_ab", 32'(done_ab), 32'd1);
        chk("t3_sym", 32'(done_sym), 32'd2);

        // abort after 4 payload bits -> no pad
        prep();
        do_start(5);
        wait_src("t4_src", 4, 50);
        src_valid = 1'b0; abort = 1'b1;
        step();
        abort = 1'b0;
        wait_done("t4_done", 50);
        chk("t4_len", 32'(got_q.size()), 32'd12);
        chk("t4_bits", pack_got(12), 32'h0000_036B);
        chk("t4_ab", 32'(done_ab), 32'd1);
        chk("t4_sym", 32'(done_sym), 32'd2);

        // abort coincident with the final bit
        prep();
        do_start(5);
        wait_src("t5_src", 9, 50);
        abort = 1'b1;
        step();
        abort = 1'b0;
        wait_done("t5_done", 50);
        chk("t5_bits", pack_got(18), 32'h0000_DAC0);
        chk("t5_ab", 32'(done_ab), 32'd0);
        chk("t5_sym", 32'(done_sym), 32'd5);

        // zero-length start is ignored
        prep();
        d0 = done_cnt;
        do_start(0);
        repeat (3) step();
        chk("t6_no_done", 32'(done_cnt), 32'(d0));
        chk("t6_idle", 32'(busy), 32'd0);

        // start mid-burst is ignored
        prep();
        do_start(3);
        repeat (10) step();
        start = 1'b1; burst_syms = 12'd7;
        step();
        start = 1'b0;
        wait_done("t7_done", 50);
        chk("t7_sym", 32'(done_sym), 32'd3);
        chk("t7_len", 32'(got_q.size()), 32'd14);

        // reset mid-preamble, then a one-symbol burst
        prep();
        do_start(2);
        repeat (3) step();
        d0 = done_cnt;
        reset = 1'b1;
        #2;
        chk("t8_rst_busy", 32'(busy), 32'd0);
        chk("t8_rst_valid", 32'(mod_valid), 32'd0);
        step(); step();
        reset = 1'b0;
        step();
        chk("t8_no_done", 32'(done_cnt), 32'(d0));
        prep();
        do_start(1);
        wait_done("t8_done", 50);
        chk("t8_len", 32'(got_q.size()), 32'd10);
        chk("t8_pre", pack_got(8), 32'h0000_0036);
        chk("t8_bits", pack_got(10), 32'h0000_00DA);
        chk("t8_sym", 32'(done_sym), 32'd1);

        // random traffic
        rnd_mode = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            start      = ($urandom_range(0, 3) == 0);
            burst_syms = ($urandom_range(0, 9) == 0) ? 12'd40 : 12'($urandom_range(0, 7));
            abort      = ($urandom_range(0, 11) == 0);
            src_valid  = ($urandom_range(0, 3) != 0);
            mod_ready  = ($urandom_range(0, 3) != 0);
            src_data   = 1'($urandom_range(0, 1));
            reset      = ($urandom_range(0, 699) == 0);
            step();
        end
        reset = 1'b0; start = 1'b0; abort = 1'b0; src_valid = 1'b0; mod_ready = 1'b0;
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/qpsk_burst_ctrl.md
# qpsk_burst_ctrl

Burst controller that sequences the serial bit stream into the QPSK modulator of the WiMAX transmit chain. On each `start` it sends a fixed preamble bit pattern, then passes exactly `2*burst_syms` payload bits from the upstream stage (randomizer/FEC/interleaver) through to the modulator. It keeps the modulator's 2-bit pairing aligned across bursts and aborts by padding any half-symbol. It reports a done pulse and the completed symbol count.

## Interface
- `BURST_LEN_W`, 12, width of the burst length in symbols
- `PREAMBLE_SYMS`, 4, preamble length in QPSK symbols (0 allowed = no preamble)
- `PREAMBLE_PATTERN`, 8'b0011_0110, preamble bits, `2*PREAMBLE_SYMS` wide, sent MSB first

Ports:
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `start`  in  1  burst request, sampled only in IDLE
- `burst_syms`  in  BURST_LEN_W  payload length in symbols, latched with `start`
- `abort`  in  1  terminate payload early, sampled only in DATA
- `src_data`  in  1  upstream payload bit
- `src_valid`  in  1  upstream bit valid
- `src_ready`  out  1  upstream bit accepted when `src_valid && src_ready`
- `mod_data`  out  1  bit to modulator `in_data`
- `mod_valid`  out  1  to modulator `in_valid`
- `mod_ready`  in  1  downstream ready, also drives modulator `in_ready`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at burst end
- `aborted`  out  1  valid with `done`: burst ended by `abort`
- `sym_count`  out  BURST_LEN_W  symbols (bit pairs) sent to the modulator in the payload so far

## Operation
- A transfer is a cycle with `mod_valid && mod_ready`. The bit counter `bit_cnt` (BURST_LEN_W+1 bits) increments once per transfer and clears on entry to PREAMBLE and to DATA.
- States: IDLE, PREAMBLE, DATA, PAD, DONE.
- IDLE: `src_ready=0`, `mod_valid=0`.
  - `start && burst_syms!=0`: latch the length, then go to PREAMBLE, or to DATA if `PREAMBLE_SYMS==0`.
  - `start && burst_syms==0`: ignored. No `done`.
- PREAMBLE: `mod_valid=1`, `mod_data=PREAMBLE_PATTERN[2*PREAMBLE_SYMS-1-bit_cnt]`, `src_ready=0`. After the transfer of bit `2*PREAMBLE_SYMS-1`, go to DATA.
- DATA: combinational pass-through.
  - `mod_data=src_data`, `mod_valid=src_valid`, `src_ready=mod_ready`.
  - After the transfer of bit `2*len-1`, go to DONE.
  - `abort` high and no completing transfer in that cycle:
    - If `bit_cnt` is even (after any same-cycle transfer), go to DONE with `aborted` set.
    - If odd, go to PAD.
  - If `abort` and the final transfer coincide, the final transfer wins: normal DONE, `aborted=0`.
- PAD: `mod_valid=1`, `mod_data=0`, `src_ready=0`. After one transfer, go to DONE with `aborted` set.
- DONE: `done=1` for exactly one cycle, `busy=1`, then IDLE.
  - `aborted` is cleared on entry to PREAMBLE/DATA from IDLE.
  - `sym_count` holds until the next burst starts.
- `sym_count = bit_cnt[BURST_LEN_W:1]` during DATA/PAD/DONE. It is 0 during PREAMBLE. The PAD bit counts toward the final symbol.
- `start` while busy is ignored. `abort` outside DATA is ignored.
- The PAD state guarantees that every burst delivers an even number of bits to the modulator, so the next burst's first symbol is pair-aligned.

## Timing
- Reset (async assert, any state): state IDLE. All outputs 0: `src_ready`, `mod_data`, `mod_valid`, `busy`, `done`, `aborted`, `sym_count`. Latched length is 0. A burst in flight is dropped without `done`.
- `start` sampled at edge k: `busy` and `mod_valid` are high from cycle k+1.
- The first preamble bit can transfer in cycle k+1.
- With continuous readiness, a burst occupies `2*PREAMBLE_SYMS + 2*burst_syms` transfer cycles, plus 1 DONE cycle.
- The next `start` is accepted in the cycle after DONE. Minimum burst-to-burst gap is 1 idle cycle.
- `src_ready` and `mod_valid` in DATA are purely combinational from inputs. There is no added latency and no buffering.
- `mod_ready` low stalls every state except IDLE/DONE. Counters and pattern index hold.
- Maximum burst is `2^BURST_LEN_W-1` symbols. `bit_cnt` never wraps.

## Test plan
- Defaults, `start` with `burst_syms=3`, source always valid with bits 1,0,1,1,0,0, `mod_ready=1` -> `mod_data` = 0,0,1,1,0,1,1,0,1,0,1,1,0,0 over 14 cycles. `done` in the next cycle, `sym_count=3`, `aborted=0`.
- Same burst with `mod_ready` toggled 1,0,1,0… -> identical bit sequence. Counters hold while low, `src_ready` low whenever `mod_ready` is low, `done` after 28 cycles.
- `burst_syms=5`, `abort` asserted after 3 payload bits -> one PAD transfer with `mod_data=0`. Then `done=1`, `aborted=1`, `sym_count=2`.
- `abort` after 4 payload bits -> no PAD. `done` the next cycle, `aborted=1`, `sym_count=2`. `abort` coincident with the 10th bit of `burst_syms=5` -> `aborted=0`, `sym_count=5`.
- `start` with `burst_syms=0` -> stays IDLE, no `done`. `start` pulsed mid-burst -> ignored, the burst completes unchanged.
- `reset` asserted mid-PREAMBLE, then released and a new `start` with `burst_syms=1` -> all outputs 0 during reset. After release, the full 8-bit preamble plus 2 bits, `sym_count=1`.
